// File: rtl/instr_mem_pkg.sv
// Shared constants and response record for the instruction-fetch memory.
package instr_mem_pkg;

  localparam int unsigned INSN_W = 32;
  localparam int unsigned ERR_W  = 2;

  localparam logic [ERR_W-1:0]  ERR_OK       = 2'b00;
  localparam logic [ERR_W-1:0]  ERR_MISALIGN = 2'b01;
  localparam logic [ERR_W-1:0]  ERR_RANGE    = 2'b10;
  localparam logic [INSN_W-1:0] NOP_INSN     = 32'h0000_0013;

  typedef struct packed {
    logic [ERR_W-1:0]  err;
    logic [INSN_W-1:0] insn;
  } rsp_t;

endpackage

// File: rtl/instr_rsp_fifo.sv
// Two-entry synchronous response FIFO; a push while full is legal when a pop happens the same cycle.
module instr_rsp_fifo
  import instr_mem_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic i_push,
  input  logic i_pop,
  input  rsp_t i_data,
  output rsp_t o_data,
  output logic o_full,
  output logic o_empty
);

  rsp_t       r_mem [2];
  logic       r_wptr;
  logic       r_rptr;
  logic [1:0] r_cnt;
  logic       w_do_push;
  logic       w_do_pop;

  always_comb begin
    o_full    = (r_cnt == 2'd2);
    o_empty   = (r_cnt == 2'd0);
    w_do_pop  = i_pop && !o_empty;
    w_do_push = i_push && (!o_full || w_do_pop);
    o_data    = r_mem[r_rptr];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr <= 1'b0;
      r_rptr <= 1'b0;
      r_cnt  <= '0;
    end else begin
      if (w_do_push) r_wptr <= ~r_wptr;
      if (w_do_pop)  r_rptr <= ~r_rptr;
      r_cnt <= r_cnt + {1'b0, w_do_push} - {1'b0, w_do_pop};
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wptr] <= i_data;
  end

endmodule

// File: rtl/instr_mem_fetch.sv
// Byte-addressed little-endian instruction memory with valid/ready fetch,
// address checking and a byte-wide programming port.
module instr_mem_fetch
  import instr_mem_pkg::*;
#(
  parameter int unsigned          ADDR_W      = 32,
  parameter int unsigned          DEPTH_BYTES = 64,
  parameter logic [ADDR_W-1:0]    BASE_ADDR   = '0,
  parameter                       INIT_FILE   = ""
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [31:0]       rsp_insn,
  output logic [1:0]        rsp_err,
  input  logic              prog_we,
  input  logic [ADDR_W-1:0] prog_addr,
  input  logic [7:0]        prog_byte
);

  localparam int unsigned       IDX_W     = $clog2(DEPTH_BYTES);
  localparam logic [ADDR_W-1:0] LAST_WORD = ADDR_W'(DEPTH_BYTES - 4);
  localparam logic [ADDR_W-1:0] LAST_BYTE = ADDR_W'(DEPTH_BYTES - 1);

  logic [7:0]        r_mem [DEPTH_BYTES];
  logic [ADDR_W-1:0] w_req_off;
  logic [ADDR_W-1:0] w_prog_off;
  logic [IDX_W-1:0]  w_idx;
  logic              w_prog_ok;
  logic              w_push;
  logic              w_pop;
  logic              w_full;
  logic              w_empty;
  rsp_t              w_rsp;
  rsp_t              w_head;

  always_comb begin
    w_req_off  = req_addr - BASE_ADDR;
    w_prog_off = prog_addr - BASE_ADDR;
    w_idx      = w_req_off[IDX_W-1:0];
    w_prog_ok  = prog_we && (prog_addr >= BASE_ADDR) && (w_prog_off <= LAST_BYTE);

    w_rsp.err  = ERR_OK;
    w_rsp.insn = NOP_INSN;
    if (req_addr[1:0] != 2'b00) begin
      w_rsp.err = ERR_MISALIGN;
    end else if ((req_addr < BASE_ADDR) || (w_req_off > LAST_WORD)) begin
      w_rsp.err = ERR_RANGE;
    end else begin
      w_rsp.insn = {r_mem[w_idx + IDX_W'(3)], r_mem[w_idx + IDX_W'(2)],
                    r_mem[w_idx + IDX_W'(1)], r_mem[w_idx]};
    end
  end

  // The array read is captured straight into the response buffer on the accept
  // edge, so the buffer entry doubles as the in-flight read stage (t+1 latency).
  always_comb begin
    rsp_valid = !w_empty;
    w_pop     = rsp_valid && rsp_ready;
    req_ready = !prog_we && (!w_full || w_pop);
    w_push    = req_valid && req_ready;
    rsp_insn  = rsp_valid ? w_head.insn : '0;
    rsp_err   = rsp_valid ? w_head.err  : ERR_OK;
  end

  always_ff @(posedge clk) begin
    if (w_prog_ok) r_mem[w_prog_off[IDX_W-1:0]] <= prog_byte;
  end

  instr_rsp_fifo u_rsp_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_data  (w_rsp),
    .o_data  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

endmodule

// File: tb/tb_instr_mem_fetch.sv
// Scoreboard bench for instr_mem_fetch: a byte-array reference model predicts each accepted fetch.
module tb_instr_mem_fetch;

  localparam int unsigned DEPTH = 64;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_insn;
  logic [1:0]  rsp_err;
  logic        prog_we;
  logic [31:0] prog_addr;
  logic [7:0]  prog_byte;

  typedef struct {
    logic [1:0]  err;
    logic [31:0] insn;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] mdl [DEPTH];
  int         n_chk;
  int         n_err;
  logic       last_rv;
  logic       last_rdy;

  instr_mem_fetch #(
    .ADDR_W      (32),
    .DEPTH_BYTES (DEPTH),
    .BASE_ADDR   (32'h0000_0000)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_addr  (req_addr),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_insn  (rsp_insn),
    .rsp_err   (rsp_err),
    .prog_we   (prog_we),
    .prog_addr (prog_addr),
    .prog_byte (prog_byte)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference: little-endian word from the byte model, or an error NOP.
  function automatic exp_t model(input logic [31:0] a);
    exp_t e;
    e.err  = 2'b00;
    e.insn = 32'h0000_0013;
    if (a[1:0] != 2'b00)      e.err = 2'b01;
    else if (a > DEPTH - 4)   e.err = 2'b10;
    else e.insn = {mdl[a + 3], mdl[a + 2], mdl[a + 1], mdl[a]};
    return e;
  endfunction

  task automatic cyc(input logic v, input logic [31:0] a, input logic rr,
                     input logic we, input logic [31:0] pa, input logic [7:0] pb,
                     output logic acc);
    @(negedge clk);
    req_valid = v;  req_addr  = a;  rsp_ready = rr;
    prog_we   = we; prog_addr = pa; prog_byte = pb;
    #2;
    last_rv  = rsp_valid;
    last_rdy = req_ready;
    acc      = v && req_ready;
    if (we) begin
      chk("prog_blocks_req", {63'd0, req_ready}, 64'd0);
      if (pa < DEPTH) mdl[pa] = pb;
    end
    if (acc) exp_q.push_back(model(a));
  endtask

  task automatic drain();
    logic acc;
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) cyc(1'b0, '0, 1'b1, 1'b0, '0, '0, acc);
    chk("drain_timeout", 64'(exp_q.size()), 64'd0);
  endtask

  // Monitor: compares the presented response with the queue head; pops on handshake.
  initial begin
    forever begin
      @(negedge clk);
      #3;
      if (!rst && rsp_valid) begin
        if (exp_q.size() == 0) begin
          chk("spurious_rsp", {32'd0, rsp_insn}, 64'd0);
        end else begin
          chk("rsp_insn", {32'd0, rsp_insn}, {32'd0, exp_q[0].insn});
          chk("rsp_err", {62'd0, rsp_err}, {62'd0, exp_q[0].err});
          if (rsp_ready) void'(exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic acc;
    int   n_acc;
    logic [31:0] a;
    n_chk = 0; n_err = 0;
    rst = 1'b1; req_valid = 0; req_addr = '0; rsp_ready = 0;
    prog_we = 0; prog_addr = '0; prog_byte = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #2;
    chk("reset_rsp_valid", {63'd0, rsp_valid}, 64'd0);
    chk("reset_rsp_insn", {32'd0, rsp_insn}, 64'd0);
    chk("reset_rsp_err", {62'd0, rsp_err}, 64'd0);
    chk("reset_req_ready", {63'd0, req_ready}, 64'd1);

    for (int i = 0; i < DEPTH; i++) begin
      logic [7:0] b;
      b = (i < 16) ? 8'(i << 4) : 8'($urandom);
      cyc(1'b0, '0, 1'b1, 1'b1, 32'(i), b, acc);
    end

    // Back-to-back aligned fetches, one response per cycle.
    cyc(1'b1, 32'h0, 1'b1, 1'b0, '0, '0, acc);
    chk("t1_acc", {63'd0, acc}, 64'd1);
    for (int i = 1; i < 4; i++) begin
      cyc(1'b1, 32'(4 * i), 1'b1, 1'b0, '0, '0, acc);
      chk("t1_acc", {63'd0, acc}, 64'd1);
      chk("t1_latency", {63'd0, last_rv}, 64'd1);
    end
    cyc(1'b0, '0, 1'b1, 1'b0, '0, '0, acc);
    chk("t1_latency", {63'd0, last_rv}, 64'd1);
    drain();

    // Misaligned, just past the end, top legal word.
    cyc(1'b1, 32'd2, 1'b1, 1'b0, '0, '0, acc);
    cyc(1'b1, 32'(DEPTH), 1'b1, 1'b0, '0, '0, acc);
    cyc(1'b1, 32'(DEPTH - 4), 1'b1, 1'b0, '0, '0, acc);
    drain();

    // Stalled consumer: only two requests fit.
    n_acc = 0;
    for (int i = 0; i < 4; i++) begin
      cyc(1'b1, {26'd0, 4'($urandom), 2'b00}, 1'b0, 1'b0, '0, '0, acc);
      if (acc) n_acc++;
    end
    chk("t3_accepted", 64'(n_acc), 64'd2);
    cyc(1'b0, '0, 1'b0, 1'b0, '0, '0, acc);
    chk("t3_ready_low", {63'd0, last_rdy}, 64'd0);
    drain();

    // Write then immediate re-fetch.
    cyc(1'b1, 32'd4, 1'b1, 1'b1, 32'd4, 8'hAA, acc);
    cyc(1'b1, 32'd4, 1'b1, 1'b0, '0, '0, acc);
    chk("t4_acc", {63'd0, acc}, 64'd1);
    drain();

    // Reset with two buffered responses.
    cyc(1'b1, 32'd0, 1'b0, 1'b0, '0, '0, acc);
    cyc(1'b1, 32'd8, 1'b0, 1'b0, '0, '0, acc);
    cyc(1'b0, '0, 1'b0, 1'b0, '0, '0, acc);
    @(negedge clk);
    rst = 1'b1; req_valid = 1'b0;
    #1;
    chk("t5_rst_valid", {63'd0, rsp_valid}, 64'd0);
    chk("t5_rst_insn", {32'd0, rsp_insn}, 64'd0);
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    cyc(1'b1, 32'd0, 1'b1, 1'b0, '0, '0, acc);
    chk("t5_ready_after_rst", {63'd0, acc}, 64'd1);
    drain();

    // Randomised traffic with interleaved programming.
    for (int i = 0; i < 400; i++) begin
      case ($urandom_range(0, 9))
        0, 1, 2, 3, 4, 5, 6: a = {26'd0, 4'($urandom), 2'b00};
        7:                   a = 32'($urandom_range(0, DEPTH + 8));
        8:                   a = 32'(DEPTH + 4 * $urandom_range(0, 4));
        default:             a = $urandom;
      endcase
      if ($urandom_range(0, 9) == 0)
        cyc($urandom_range(0, 1) == 1, a, $urandom_range(0, 3) != 0, 1'b1,
            32'($urandom_range(0, DEPTH + 6)), 8'($urandom), acc);
      else
        cyc($urandom_range(0, 3) != 0, a, $urandom_range(0, 3) != 0, 1'b0, '0, '0, acc);
    end
    drain();

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
